// File: rtl/axil_cfg_pkg.sv
// Shared types and constants for the AXI4-Lite configuration sequencer.
// AXIL_CFG_READBACK_EN adds the read-back states to the state enum.
package axil_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
`ifdef AXIL_CFG_READBACK_EN
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_CHECK,
`endif
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BRESP    = 3'd1;
    localparam logic [2:0] ERR_RRESP    = 3'd2;
    localparam logic [2:0] ERR_MISMATCH = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // A single-entry table still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axil_cfg_watchdog.sv
// Handshake watchdog: counts cycles while enabled, restarts on clear and
// flags expiry once the count reaches the loaded limit.
module axil_cfg_watchdog #(
    parameter int WIDTH = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expire_o = enable_i && (cnt_q == limit_i);

endmodule

// File: rtl/axil_cfg_sequencer.sv
// AXI4-Lite master that writes a parent-supplied (offset, value) table into a slave.
// Define AXIL_CFG_READBACK_EN to read each entry back and compare it.
module axil_cfg_sequencer
    import axil_cfg_pkg::*;
#(
    parameter int                    NUM_ENTRIES    = 4,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    TIMEOUT_CYCLES = 1024,
    localparam int                   IDXW           = idx_width(NUM_ENTRIES)
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [2:0]              err_code,
    output logic [IDXW-1:0]         err_idx,
    output logic [IDXW-1:0]         tbl_idx,
    input  logic [ADDR_WIDTH-1:0]   tbl_offset,
    input  logic [DATA_WIDTH-1:0]   tbl_data,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    state_e                state_q, state_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [2:0]            code_q, code_d;
    logic [IDXW-1:0]       err_idx_q, err_idx_d;
    logic                  wdog_clear;
    logic                  wdog_en;
    logic                  wdog_expire;
`ifdef AXIL_CFG_READBACK_EN
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            code_q    <= ERR_NONE;
            err_idx_q <= '0;
`ifdef AXIL_CFG_READBACK_EN
            rdata_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            done_q    <= done_d;
            error_q   <= error_d;
            code_q    <= code_d;
            err_idx_q <= err_idx_d;
`ifdef AXIL_CFG_READBACK_EN
            rdata_q   <= rdata_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        done_d    = done_q;
        error_d   = error_q;
        code_d    = code_q;
        err_idx_d = err_idx_q;
`ifdef AXIL_CFG_READBACK_EN
        rdata_d   = rdata_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    code_d  = ERR_NONE;
                    idx_d   = '0;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                awvalid_d = awvalid_q && !M_AXI_AWREADY;
                wvalid_d  = wvalid_q && !M_AXI_WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != RESP_OKAY) begin
                        state_d = ST_ERR;
                        code_d  = ERR_BRESP;
                    end else begin
`ifdef AXIL_CFG_READBACK_EN
                        state_d = ST_RD_ADDR;
`else
                        state_d = ST_NEXT;
`endif
                    end
                end
            end
`ifdef AXIL_CFG_READBACK_EN
            ST_RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    if (M_AXI_RRESP != RESP_OKAY) begin
                        state_d = ST_ERR;
                        code_d  = ERR_RRESP;
                    end else begin
                        rdata_d = M_AXI_RDATA;
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (rdata_q != wdata_q) begin
                    state_d = ST_ERR;
                    code_d  = ERR_MISMATCH;
                end else begin
                    state_d = ST_NEXT;
                end
            end
`endif
            ST_NEXT: begin
                if (idx_q == IDXW'(NUM_ENTRIES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_WR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (wdog_expire) begin
            state_d = ST_ERR;
            code_d  = ERR_TIMEOUT;
        end

        // Address and data are captured once per entry so they stay stable under backpressure.
        if (state_d == ST_WR && state_q != ST_WR) begin
            addr_d    = BASE_ADDR + tbl_offset;
            wdata_d   = tbl_data;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
        end
        if (state_d == ST_ERR && state_q != ST_ERR) begin
            error_d   = 1'b1;
            err_idx_d = idx_q;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
        end
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            done_d = 1'b1;
        end
    end

    always_comb begin
        wdog_en = (state_q == ST_WR) || (state_q == ST_WR_RESP);
`ifdef AXIL_CFG_READBACK_EN
        if (state_q == ST_RD_ADDR || state_q == ST_RD_DATA) begin
            wdog_en = 1'b1;
        end
`endif
    end

    assign wdog_clear = (state_d != state_q);

    axil_cfg_watchdog #(
        .WIDTH(WDW)
    ) u_watchdog (
        .clk_i    (ACLK),
        .rst_ni   (ARESETN),
        .clear_i  (wdog_clear),
        .enable_i (wdog_en),
        .limit_i  (WDW'(TIMEOUT_CYCLES - 1)),
        .expire_o (wdog_expire)
    );

    // The parent looks up the entry about to be loaded, so expose the next index.
    assign tbl_idx  = idx_d;
    assign busy     = !(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = code_q;
    assign err_idx  = err_idx_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (state_q == ST_WR_RESP);
    assign M_AXI_ARPROT  = 3'b000;

`ifdef AXIL_CFG_READBACK_EN
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = (state_q == ST_RD_ADDR);
    assign M_AXI_RREADY  = (state_q == ST_RD_DATA);
`else
    logic unused_rd;
    assign unused_rd     = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
    assign M_AXI_ARADDR  = '0;
    assign M_AXI_ARVALID = 1'b0;
    assign M_AXI_RREADY  = 1'b0;
`endif

endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// Scoreboard bench for axil_cfg_sequencer with a reactive AXI4-Lite slave model.
// Expectations follow AXIL_CFG_READBACK_EN when it is defined for the build.
module tb_axil_cfg_sequencer;

`ifdef AXIL_CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        ACLK;
    logic        ARESETN;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  err_code;
    logic [1:0]  err_idx;
    logic [1:0]  tbl_idx;
    logic [31:0] tbl_offset;
    logic [31:0] tbl_data;
    logic [31:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    logic [31:0] offTab  [0:3] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] dataTab [0:3] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};

    int checks = 0;
    int errors = 0;

    // Slave behaviour knobs
    int awDelayEntry  = -1;
    bit awStallAll    = 1'b0;
    int brespErrEntry = -1;
    bit corruptOn     = 1'b0;

    // Slave state
    logic [31:0] mem [0:3];
    logic        awGot, wGot;
    logic [31:0] awAddrQ, wDataQ;
    logic [1:0]  awDly;
    int          wrCount;
    logic        bvalidQ, rvalidQ;
    logic [1:0]  brespQ;
    logic [31:0] rdataQ;

    // Scoreboard queues
    logic [31:0] expWrAddr[$];
    logic [31:0] expWrData[$];
    logic [31:0] expRdAddr[$];
    logic [31:0] obsAw[$];
    logic [31:0] obsW[$];

    logic        awStallPrev, wStallPrev;
    logic [31:0] awAddrPrev, wDataPrev;
    logic [31:0] monA, monD;

    axil_cfg_sequencer #(
        .NUM_ENTRIES    (4),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .BASE_ADDR      (32'h0),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_code      (err_code),
        .err_idx       (err_idx),
        .tbl_idx       (tbl_idx),
        .tbl_offset    (tbl_offset),
        .tbl_data      (tbl_data),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARPROT  (M_AXI_ARPROT),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    assign tbl_offset = offTab[tbl_idx];
    assign tbl_data   = dataTab[tbl_idx];

    // Slave handshake outputs
    assign M_AXI_AWREADY = awStallAll ? 1'b0 : ((wrCount == awDelayEntry) ? (awDly == 2'd3) : 1'b1);
    assign M_AXI_WREADY  = 1'b1;
    assign M_AXI_BVALID  = bvalidQ;
    assign M_AXI_BRESP   = brespQ;
    assign M_AXI_ARREADY = 1'b1;
    assign M_AXI_RVALID  = rvalidQ;
    assign M_AXI_RDATA   = rdataQ;
    assign M_AXI_RRESP   = 2'b00;

    // Slave model: stores writes, answers reads, injects the configured faults
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awGot   <= 1'b0;
            wGot    <= 1'b0;
            awAddrQ <= '0;
            wDataQ  <= '0;
            awDly   <= 2'd0;
            wrCount <= 0;
            bvalidQ <= 1'b0;
            brespQ  <= 2'b00;
            rvalidQ <= 1'b0;
            rdataQ  <= '0;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            if (bvalidQ && M_AXI_BREADY) begin
                bvalidQ <= 1'b0;
                wrCount <= wrCount + 1;
                awDly   <= 2'd0;
            end else begin
                if (M_AXI_WVALID && M_AXI_WREADY) awDly <= 2'd1;
                else if (awDly != 2'd0 && awDly != 2'd3) awDly <= awDly + 2'd1;
                if (!bvalidQ) begin
                    if ((awGot || (M_AXI_AWVALID && M_AXI_AWREADY)) &&
                        (wGot || (M_AXI_WVALID && M_AXI_WREADY))) begin
                        bvalidQ <= 1'b1;
                        brespQ  <= (wrCount == brespErrEntry) ? 2'b10 : 2'b00;
                        mem[(awGot ? awAddrQ[3:2] : M_AXI_AWADDR[3:2])] <= wGot ? wDataQ : M_AXI_WDATA;
                        awGot   <= 1'b0;
                        wGot    <= 1'b0;
                    end else begin
                        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                            awGot   <= 1'b1;
                            awAddrQ <= M_AXI_AWADDR;
                        end
                        if (M_AXI_WVALID && M_AXI_WREADY) begin
                            wGot   <= 1'b1;
                            wDataQ <= M_AXI_WDATA;
                        end
                    end
                end
            end
            if (rvalidQ && M_AXI_RREADY) begin
                rvalidQ <= 1'b0;
            end else if (!rvalidQ && M_AXI_ARVALID && M_AXI_ARREADY) begin
                rvalidQ <= 1'b1;
                rdataQ  <= (corruptOn && M_AXI_ARADDR == 32'h8) ? 32'hDEAD0010 : mem[M_AXI_ARADDR[3:2]];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Monitor: pairs observed AW/W handshakes and AR handshakes against the expected queues
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            awStallPrev = 1'b0;
            wStallPrev  = 1'b0;
        end else begin
            if (M_AXI_AWVALID && awStallPrev) checkOutput("AWADDR stable", M_AXI_AWADDR, awAddrPrev);
            if (M_AXI_WVALID && wStallPrev)   checkOutput("WDATA stable", M_AXI_WDATA, wDataPrev);
            awStallPrev = M_AXI_AWVALID && !M_AXI_AWREADY;
            wStallPrev  = M_AXI_WVALID && !M_AXI_WREADY;
            awAddrPrev  = M_AXI_AWADDR;
            wDataPrev   = M_AXI_WDATA;
            if (M_AXI_AWVALID && M_AXI_AWREADY) obsAw.push_back(M_AXI_AWADDR);
            if (M_AXI_WVALID && M_AXI_WREADY)   obsW.push_back(M_AXI_WDATA);
            if (obsAw.size() > 0 && obsW.size() > 0) begin
                monA = obsAw.pop_front();
                monD = obsW.pop_front();
                if (expWrAddr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected write actual addr=%0h data=%0h required none", monA, monD);
                end else begin
                    checkOutput("write addr", monA, expWrAddr.pop_front());
                    checkOutput("write data", monD, expWrData.pop_front());
                end
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                if (expRdAddr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected read actual addr=%0h required none", M_AXI_ARADDR);
                end else begin
                    checkOutput("read addr", M_AXI_ARADDR, expRdAddr.pop_front());
                end
            end
        end
    end

    task automatic pushWrites(input int n);
        for (int i = 0; i < n; i++) begin
            expWrAddr.push_back(offTab[i]);
            expWrData.push_back(dataTab[i]);
        end
    endtask

    task automatic pushReads(input int n);
        for (int i = 0; i < n; i++) expRdAddr.push_back(offTab[i]);
    endtask

    task automatic resetDut();
        ARESETN = 1'b0;
        start   = 1'b0;
        repeat (2) @(posedge ACLK);
        expWrAddr.delete();
        expWrData.delete();
        expRdAddr.delete();
        obsAw.delete();
        obsW.delete();
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " error"}, error, 0);
        checkOutput({tag, " err_code"}, err_code, 0);
        checkOutput({tag, " err_idx"}, err_idx, 0);
        checkOutput({tag, " tbl_idx"}, tbl_idx, 0);
        checkOutput({tag, " valids"}, {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
    endtask

    task automatic checkStatus(input string tag, input logic expDone, input logic expErr,
                               input logic [2:0] expCode, input logic [1:0] expIdx);
        checkOutput({tag, " done"}, done, expDone);
        checkOutput({tag, " error"}, error, expErr);
        checkOutput({tag, " err_code"}, err_code, expCode);
        checkOutput({tag, " err_idx"}, err_idx, expIdx);
        checkOutput({tag, " busy"}, busy, 0);
    endtask

    task automatic checkDrained(input string tag);
        checkOutput({tag, " pending writes"}, expWrAddr.size(), 0);
        checkOutput({tag, " pending reads"}, expRdAddr.size(), 0);
    endtask

    // Pulse start, then count cycles until done or error; optional second start while busy
    task automatic applyStimulus(input string tag, input int pulseAt, output int cyc);
        @(negedge ACLK);
        start = 1'b1;
        @(posedge ACLK);
        #1;
        start = 1'b0;
        checkOutput({tag, " busy after start"}, busy, 1);
        cyc = 0;
        while (!(done || error) && cyc < 300) begin
            @(posedge ACLK);
            #1;
            cyc++;
            start = (cyc == pulseAt);
        end
        start = 1'b0;
        if (!(done || error)) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s completion actual=none required=done_or_error", tag);
        end
    endtask

    int cyc;
    int waitCnt;

    initial begin
        ARESETN = 1'b0;
        start   = 1'b0;
        #1;
        checkResetState("reset");
        resetDut();
        checkResetState("post-reset");

        // Zero-wait slave, full table, extra start while busy must be ignored
        pushWrites(4);
        if (RB) pushReads(4);
        applyStimulus("zero-wait", 8, cyc);
        checkOutput("zero-wait cycles", cyc, RB ? 24 : 12);
        checkStatus("zero-wait", 1'b1, 1'b0, 3'd0, 2'd0);
        checkDrained("zero-wait");

        // AWREADY arrives three cycles after WREADY on entry 1
        resetDut();
        awDelayEntry = 1;
        pushWrites(4);
        if (RB) pushReads(4);
        applyStimulus("aw-delay", 0, cyc);
        checkOutput("aw-delay cycles", cyc, RB ? 27 : 15);
        checkStatus("aw-delay", 1'b1, 1'b0, 3'd0, 2'd0);
        checkDrained("aw-delay");
        awDelayEntry = -1;

        // SLVERR on entry 2 write response
        resetDut();
        brespErrEntry = 2;
        pushWrites(3);
        if (RB) pushReads(2);
        applyStimulus("bresp", 0, cyc);
        checkOutput("bresp cycles", cyc, RB ? 14 : 8);
        checkStatus("bresp", 1'b0, 1'b1, 3'd1, 2'd2);
        repeat (4) @(posedge ACLK);
        #1;
        checkDrained("bresp");
        brespErrEntry = -1;

        // Corrupted readback on entry 2, then a clean restart from ERR
        resetDut();
        corruptOn = 1'b1;
        pushWrites(RB ? 3 : 4);
        if (RB) pushReads(3);
        applyStimulus("mismatch", 0, cyc);
        checkOutput("mismatch cycles", cyc, RB ? 17 : 12);
        checkStatus("mismatch", !RB, RB, RB ? 3'd3 : 3'd0, RB ? 2'd2 : 2'd0);
        checkDrained("mismatch");
        corruptOn = 1'b0;
        pushWrites(4);
        if (RB) pushReads(4);
        applyStimulus("restart", 0, cyc);
        checkOutput("restart cycles", cyc, RB ? 24 : 12);
        checkStatus("restart", 1'b1, 1'b0, 3'd0, RB ? 2'd2 : 2'd0);
        checkDrained("restart");

        // AWREADY never arrives: watchdog abort
        resetDut();
        awStallAll = 1'b1;
        applyStimulus("timeout", 0, cyc);
        checkOutput("timeout cycles", cyc, 16);
        checkStatus("timeout", 1'b0, 1'b1, 3'd4, 2'd0);
        checkOutput("timeout valids", {M_AXI_AWVALID, M_AXI_WVALID}, 0);
        awStallAll = 1'b0;

        // Reset asserted in the middle of entry 0, then a full restart
        resetDut();
        pushWrites(1);
        if (RB) pushReads(1);
        @(negedge ACLK);
        start = 1'b1;
        @(posedge ACLK);
        #1;
        start = 1'b0;
        waitCnt = 0;
        while (!(RB ? M_AXI_RREADY : M_AXI_BREADY) && waitCnt < 50) begin
            @(posedge ACLK);
            #1;
            waitCnt++;
        end
        checkOutput("mid-reset reached", RB ? M_AXI_RREADY : M_AXI_BREADY, 1);
        ARESETN = 1'b0;
        #1;
        checkResetState("mid-reset");
        checkDrained("mid-reset");
        resetDut();
        pushWrites(4);
        if (RB) pushReads(4);
        applyStimulus("after-reset", 0, cyc);
        checkOutput("after-reset cycles", cyc, RB ? 24 : 12);
        checkStatus("after-reset", 1'b1, 1'b0, 3'd0, 2'd0);
        checkDrained("after-reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
